// File: rtl/y86_bus_mem_if.sv
// CPU data bus plus byte-stream loader port and status outputs of the Y86 memory.
// The master drives requests and loader bytes; the slave returns read data and status.
interface y86_bus_mem_if;
  logic [31:0] bus_A;
  logic        bus_RE;
  logic        bus_WE;
  logic [31:0] bus_out;
  logic [31:0] bus_in;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_rst;
  logic        err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  modport master (
    output bus_A, bus_RE, bus_WE, bus_out, ld_valid, ld_data, ld_last,
    input  bus_in, ld_ready, cpu_rst, err, rd_count, wr_count
  );

  modport slave (
    input  bus_A, bus_RE, bus_WE, bus_out, ld_valid, ld_data, ld_last,
    output bus_in, ld_ready, cpu_rst, err, rd_count, wr_count
  );
endinterface

// File: rtl/y86_bus_mem.sv
// Byte-addressed Y86 memory: filled by a byte loader while the CPU is held in reset,
// then serves unaligned little-endian 32-bit reads (combinational) and writes (on edge).
module y86_bus_mem #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  y86_bus_mem_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_ptr;
  logic               r_cpu_rst;
  logic               r_err;
  logic [15:0]        r_rd_cnt;
  logic [15:0]        r_wr_cnt;

  logic               w_ld_ready;
  logic               w_ld_acc;
  logic               w_run;
  logic               w_in_range;
  logic               w_cpu_wr;
  logic               w_err_set;
  logic [ADDR_W-1:0]  w_a [4];
  logic [31:0]        w_rd_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_LOAD;
      r_cpu_rst <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cpu_rst <= (w_state_nxt == S_LOAD);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_ready  = 1'b0;
    w_ld_acc    = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_ld_ready = 1'b1;
        w_ld_acc   = bus.ld_valid;
        if (bus.ld_valid && bus.ld_last)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  assign w_run      = (r_state == S_RUN);
  assign w_in_range = (bus.bus_A[31:ADDR_W] == '0);
  assign w_cpu_wr   = w_run && bus.bus_WE && w_in_range;
  assign w_err_set  = (!w_run && (bus.bus_RE || bus.bus_WE))
                   || (w_run && bus.bus_RE && bus.bus_WE)
                   || (w_run && (bus.bus_RE || bus.bus_WE) && !w_in_range);

  // Byte lanes wrap around the top of memory, so unaligned accesses never fault.
  always_comb begin
    for (int k = 0; k < 4; k++)
      w_a[k] = bus.bus_A[ADDR_W-1:0] + ADDR_W'(k);
  end

  always_comb begin
    w_rd_dat = '0;
    if (w_run) begin
      for (int k = 0; k < 4; k++)
        w_rd_dat[8*k +: 8] = r_mem[w_a[k]];
    end
  end

  // Memory deliberately has no reset so a program survives a CPU reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_ld_acc)
        r_mem[r_ptr] <= bus.ld_data;
      if (w_cpu_wr) begin
        for (int k = 0; k < 4; k++)
          r_mem[w_a[k]] <= bus.bus_out[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (w_ld_acc)
      r_ptr <= r_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_err_set)
      r_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_run && bus.bus_RE && (r_rd_cnt != 16'hFFFF))
        r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_run && bus.bus_WE && (r_wr_cnt != 16'hFFFF))
        r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign bus.bus_in   = w_rd_dat;
  assign bus.ld_ready = w_ld_ready;
  assign bus.cpu_rst  = r_cpu_rst;
  assign bus.err      = r_err;
  assign bus.rd_count = r_rd_cnt;
  assign bus.wr_count = r_wr_cnt;
endmodule
